// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access path: transfer size
// encodings, sequencer state encoding and the size-to-beat-count helper.
package dmem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BEAT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Request attributes captured at grant time and held for the whole transfer.
  typedef struct packed {
    logic       write;
    logic [1:0] size;
    logic       uns;
  } req_attr_t;

  // Number of single-byte memory beats for a size code; 0 marks the reserved code.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: return 3'd1;
      SIZE_HALF: return 3'd2;
      SIZE_WORD: return 3'd4;
      default:   return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. On a tie the side that did not win last time
// is granted. The history bit resets to 1 so requester 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       arb_en,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic last_grant;

  // Pick a winner combinationally; alternate only when both sides ask.
  always_comb begin
    gnt_valid = arb_en & (|req);
    if (req == 2'b11) gnt_id = ~last_grant;
    else              gnt_id = req[1];
  end

  // Remember who won the most recent arbitration.
  always_ff @(posedge clk) begin
    if (rst)            last_grant <= 1'b1;
    else if (gnt_valid) last_grant <= gnt_id;
  end

endmodule

// File: rtl/dmem_access_arbiter.sv
// Shares a byte-wide data memory between the CPU load/store unit (requester 0)
// and the debug/loader port (requester 1). Each byte/half/word request is split
// into little-endian single-byte beats; load results are sign- or zero-extended.
// Misaligned, reserved-size and out-of-range requests complete with an error
// and never strobe the memory.
module dmem_access_arbiter
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              CpuReq,
  input  logic              CpuWrite,
  input  logic [1:0]        CpuSize,
  input  logic              CpuUnsigned,
  input  logic [ADDR_W-1:0] CpuAddress,
  input  logic [31:0]       CpuWriteData,
  output logic              CpuReady,
  output logic              CpuError,
  output logic [31:0]       CpuReadData,
  input  logic              DbgReq,
  input  logic              DbgWrite,
  input  logic [1:0]        DbgSize,
  input  logic              DbgUnsigned,
  input  logic [ADDR_W-1:0] DbgAddress,
  input  logic [31:0]       DbgWriteData,
  output logic              DbgReady,
  output logic              DbgError,
  output logic [31:0]       DbgReadData,
  output logic              GrantId,
  output logic              MemReadEnable,
  output logic              MemWriteEnable,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [7:0]        MemWriteData,
  input  logic [7:0]        MemReadData
);

  localparam int AW1 = ADDR_W + 1;

  // Raw little-endian bytes widened to 32 bits from the top bit of the transfer.
  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  size,
                                              input logic        uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = raw[7:0];
    h = raw[15:0];
    case (size)
      SIZE_BYTE: return uns ? {24'h0, raw[7:0]}  : {{24{b[7]}}, raw[7:0]};
      SIZE_HALF: return uns ? {16'h0, raw[15:0]} : {{16{h[15]}}, raw[15:0]};
      default:   return raw;
    endcase
  endfunction

  // Control state
  logic [1:0] state;
  logic [1:0] beat_k;
  logic       gnt_q;
  logic       err_q;
  req_attr_t  attr_q;
  logic [31:0] cpu_rd_q;
  logic [31:0] dbg_rd_q;

  // Transfer data captured at grant time / assembled during load beats
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       rbuf_q;

  // Arbitration and selected request
  logic              gnt_valid;
  logic              gnt_id;
  req_attr_t         sel_attr;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [2:0]        sel_bytes;
  logic [AW1-1:0]    sel_end;
  logic              sel_misalign;
  logic              sel_bad;

  logic [2:0]  bytes_q;
  logic        last_beat;
  logic        in_beat;
  logic        done;
  logic        load_ok;
  logic [31:0] ext_val;

  rr_arbiter2 u_arb (
    .clk       (Clock),
    .rst       (Reset),
    .req       ({DbgReq, CpuReq}),
    .arb_en    (state == ST_IDLE),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the winning requester's fields and classify the access.
  always_comb begin
    sel_attr.write = gnt_id ? DbgWrite     : CpuWrite;
    sel_attr.size  = gnt_id ? DbgSize      : CpuSize;
    sel_attr.uns   = gnt_id ? DbgUnsigned  : CpuUnsigned;
    sel_addr       = gnt_id ? DbgAddress   : CpuAddress;
    sel_wdata      = gnt_id ? DbgWriteData : CpuWriteData;
    sel_bytes      = size_to_bytes(sel_attr.size);
    // one extra bit so an address near the top of the space cannot wrap into range
    sel_end        = {1'b0, sel_addr} + AW1'(sel_bytes);
    sel_misalign   = ((sel_attr.size == SIZE_HALF) && sel_addr[0]) ||
                     ((sel_attr.size == SIZE_WORD) && (sel_addr[1:0] != 2'b00));
    sel_bad        = (sel_attr.size == SIZE_RSVD) || sel_misalign ||
                     (sel_end > AW1'(DEPTH));
  end

  // Beat bookkeeping and result extension for the transfer in flight.
  always_comb begin
    bytes_q   = size_to_bytes(attr_q.size);
    last_beat = ({1'b0, beat_k} == (bytes_q - 3'd1));
    in_beat   = (state == ST_BEAT);
    done      = (state == ST_DONE);
    load_ok   = done & ~attr_q.write & ~err_q;
    ext_val   = extend_load(rbuf_q, attr_q.size, attr_q.uns);
  end

  // Memory port: strobes and address only while beating, otherwise all zero.
  always_comb begin
    MemReadEnable  = in_beat & ~attr_q.write;
    MemWriteEnable = in_beat & attr_q.write;
    MemAddress     = in_beat ? (addr_q + ADDR_W'(beat_k)) : '0;
    MemWriteData   = (in_beat & attr_q.write) ? wdata_q[{beat_k, 3'b000} +: 8] : 8'h00;
  end

  // Requester-facing completion: only the owner sees Ready; read data is
  // presented live in DONE and held in a per-requester register afterwards.
  always_comb begin
    GrantId     = gnt_q;
    CpuReady    = done & ~gnt_q;
    DbgReady    = done & gnt_q;
    CpuError    = CpuReady & err_q;
    DbgError    = DbgReady & err_q;
    CpuReadData = (load_ok & ~gnt_q) ? ext_val : cpu_rd_q;
    DbgReadData = (load_ok & gnt_q)  ? ext_val : dbg_rd_q;
  end

  // Sequencer: IDLE grants and classifies, BEAT walks the bytes, DONE completes.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= ST_IDLE;
      beat_k   <= 2'd0;
      gnt_q    <= 1'b0;
      err_q    <= 1'b0;
      attr_q   <= '0;
      cpu_rd_q <= 32'h0;
      dbg_rd_q <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_valid) begin
            gnt_q  <= gnt_id;
            attr_q <= sel_attr;
            err_q  <= sel_bad;
            beat_k <= 2'd0;
            state  <= sel_bad ? ST_DONE : ST_BEAT;
          end
        end
        ST_BEAT: begin
          if (last_beat) state <= ST_DONE;
          else           beat_k <= beat_k + 2'd1;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          if (load_ok) begin
            if (gnt_q) dbg_rd_q <= ext_val;
            else       cpu_rd_q <= ext_val;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Transfer data path: capture request payload at grant, collect load bytes per beat.
  always_ff @(posedge Clock) begin
    if ((state == ST_IDLE) && gnt_valid) begin
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      rbuf_q  <= 32'h0;
    end else if (in_beat && !attr_q.write) begin
      rbuf_q[{beat_k, 3'b000} +: 8] <= MemReadData;
    end
  end

endmodule
